// File: rtl/prng_pkg.sv
// Shared definitions for the xorshift32 generator: register map,
// CTRL bit positions, default seed and the xorshift step function.
package prng_pkg;

  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_SEED  = 2'd1;
  localparam logic [1:0] ADDR_DIV   = 2'd2;
  localparam logic [1:0] ADDR_COUNT = 2'd3;

  localparam int CTRL_RUN_BIT    = 0;
  localparam int CTRL_STEP_BIT   = 1;
  localparam int CTRL_RESEED_BIT = 2;

  localparam logic [31:0] SEED_DEFAULT_VALUE = 32'h2545F491;

  // One xorshift32 step; shifts truncate to 32 bits.
  function automatic logic [31:0] xorshift32_next(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

endpackage

// File: rtl/prng_rate_div.sv
// 16-bit reloadable down-counter that paces free-running steps.
// tc_o is high in a cycle where the counter sits at zero while enabled;
// the generator steps on the clock edge ending that cycle, and the
// counter reloads on the same edge. A load always wins over a terminal count.
module prng_rate_div
  import prng_pkg::*;
#(
  parameter logic [15:0] RESET_VALUE = 16'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable_i,
  input  logic        load_i,
  input  logic [15:0] loadValue_i,
  output logic        tc_o
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  assign tc_o = enable_i && !load_i && (count_q == 16'd0);

  // Next count: explicit load, else decrement with reload at zero, else hold.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = loadValue_i;
    end else if (enable_i) begin
      if (count_q == 16'd0) begin
        count_d = loadValue_i;
      end else begin
        count_d = count_q - 16'd1;
      end
    end
  end

  // Counter register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= RESET_VALUE;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/prng_xorshift_gen.sv
// xorshift32 generator with an Avalon-MM control slave. The state register
// drives prng_out directly; prng_step flags the cycle a new word appears.
// Reseed beats any coincident step, and a COUNT write beats a coincident increment.
module prng_xorshift_gen
  import prng_pkg::*;
#(
  parameter logic [31:0] SEED_DEFAULT = SEED_DEFAULT_VALUE,
  parameter logic [15:0] DIV_RESET    = 16'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic [31:0] prng_out,
  output logic        prng_step
);

  logic        run_q, run_d;
  logic [31:0] seed_q, seed_d;
  logic [15:0] div_q, div_d;
  logic [31:0] count_q, count_d;
  logic [31:0] state_q, state_d;
  logic        stepReq_q, stepReq_d;
  logic        step_q, step_d;
  logic [31:0] readData_q, readData_d;

  logic        wrCtrl, wrSeed, wrDiv, wrCount;
  logic        reseed, doStep, divLoad, divTc;
  logic [15:0] divReload;
  logic [31:0] reseedValue;

  assign wrCtrl  = avs_write && (avs_address == ADDR_CTRL);
  assign wrSeed  = avs_write && (avs_address == ADDR_SEED);
  assign wrDiv   = avs_write && (avs_address == ADDR_DIV);
  assign wrCount = avs_write && (avs_address == ADDR_COUNT);

  assign reseed      = wrCtrl && avs_writedata[CTRL_RESEED_BIT];
  assign reseedValue = (seed_q == 32'd0) ? SEED_DEFAULT : seed_q;

  // A DIV write reloads with the freshly written value, otherwise with DIV.
  assign divReload = wrDiv ? avs_writedata[15:0] : div_q;
  assign divLoad   = reseed || wrDiv ||
                     (wrCtrl && avs_writedata[CTRL_RUN_BIT] && !run_q);

  prng_rate_div #(
    .RESET_VALUE (DIV_RESET)
  ) u_rate_div (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable_i    (run_q),
    .load_i      (divLoad),
    .loadValue_i (divReload),
    .tc_o        (divTc)
  );

  // Both request sources merge into a single step; reseed suppresses it.
  assign doStep = (stepReq_q || divTc) && !reseed;

  // Next-state for the register file, generator state, counter and read port.
  always_comb begin
    run_d      = run_q;
    seed_d     = seed_q;
    div_d      = div_q;
    count_d    = count_q;
    state_d    = state_q;
    readData_d = readData_q;
    stepReq_d  = wrCtrl && avs_writedata[CTRL_STEP_BIT] && !reseed;
    step_d     = doStep;

    if (wrCtrl) run_d = avs_writedata[CTRL_RUN_BIT];
    if (wrSeed) seed_d = avs_writedata;
    if (wrDiv)  div_d = avs_writedata[15:0];

    if (reseed) begin
      state_d = reseedValue;
    end else if (doStep) begin
      state_d = xorshift32_next(state_q);
    end

    if (wrCount) begin
      count_d = 32'd0;
    end else if (doStep) begin
      count_d = count_q + 32'd1;
    end

    if (avs_read) begin
      case (avs_address)
        ADDR_CTRL:  readData_d = {31'd0, run_q};
        ADDR_SEED:  readData_d = seed_q;
        ADDR_DIV:   readData_d = {16'd0, div_q};
        ADDR_COUNT: readData_d = count_q;
        default:    readData_d = 32'd0;
      endcase
    end
  end

  // All registers share one asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q      <= 1'b0;
      seed_q     <= 32'd0;
      div_q      <= DIV_RESET;
      count_q    <= 32'd0;
      state_q    <= SEED_DEFAULT;
      stepReq_q  <= 1'b0;
      step_q     <= 1'b0;
      readData_q <= 32'd0;
    end else begin
      run_q      <= run_d;
      seed_q     <= seed_d;
      div_q      <= div_d;
      count_q    <= count_d;
      state_q    <= state_d;
      stepReq_q  <= stepReq_d;
      step_q     <= step_d;
      readData_q <= readData_d;
    end
  end

  assign prng_out     = state_q;
  assign prng_step    = step_q;
  assign avs_readdata = readData_q;

endmodule

// File: tb/tb_prng_xorshift_gen.sv
// Directed bench for prng_xorshift_gen. Register reads go through an
// expected-value queue; generator output is checked against a local xorshift model.
module tb_prng_xorshift_gen;

  localparam logic [31:0] DEFAULT_SEED = 32'h2545F491;
  localparam logic [1:0]  A_CTRL  = 2'd0;
  localparam logic [1:0]  A_SEED  = 2'd1;
  localparam logic [1:0]  A_DIV   = 2'd2;
  localparam logic [1:0]  A_COUNT = 2'd3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic [31:0] prng_out;
  logic        prng_step;

  int          passCount = 0;
  int          checkCount = 0;
  logic [31:0] expQ[$];
  logic [31:0] modelState;
  logic [31:0] modelCount;

  prng_xorshift_gen dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .prng_out      (prng_out),
    .prng_step     (prng_step)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Reference xorshift32 written with explicit slices.
  function automatic logic [31:0] refNext(input logic [31:0] v);
    logic [31:0] r;
    r = v ^ {v[18:0], 13'b0};
    r = r ^ {17'b0, r[31:17]};
    r = r ^ {r[26:0], 5'b0};
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
  endtask

  // One bus cycle starting and ending on a falling edge.
  task automatic applyStimulus(input logic wr, input logic rd,
                               input logic [1:0] addr, input logic [31:0] data);
    avs_write     = wr;
    avs_read      = rd;
    avs_address   = addr;
    avs_writedata = data;
    @(negedge clk);
    avs_write     = 1'b0;
    avs_read      = 1'b0;
    avs_writedata = 32'd0;
  endtask

  task automatic writeReg(input logic [1:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b0, addr, data);
  endtask

  task automatic readReg(input string tag, input logic [1:0] addr,
                         input logic [31:0] expected);
    expQ.push_back(expected);
    applyStimulus(1'b0, 1'b1, addr, 32'd0);
    checkOutput(tag, avs_readdata, expQ.pop_front());
  endtask

  // Software single step: request edge, then the edge that updates the state.
  task automatic stepOnce(input string tag);
    writeReg(A_CTRL, 32'h2);
    checkOutput({tag, "_noPulseYet"}, {31'd0, prng_step}, 32'd0);
    @(negedge clk);
    modelState = refNext(modelState);
    modelCount = modelCount + 32'd1;
    checkOutput({tag, "_out"}, prng_out, modelState);
    checkOutput({tag, "_pulse"}, {31'd0, prng_step}, 32'd1);
    @(negedge clk);
    checkOutput({tag, "_pulseEnd"}, {31'd0, prng_step}, 32'd0);
  endtask

  // Linear sequence of directed steps.
  initial begin
    reset_n       = 1'b0;
    avs_address   = 2'd0;
    avs_write     = 1'b0;
    avs_writedata = 32'd0;
    avs_read      = 1'b0;
    modelState    = DEFAULT_SEED;
    modelCount    = 32'd0;

    repeat (2) @(negedge clk);
    checkOutput("inResetOut", prng_out, DEFAULT_SEED);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("resetOut", prng_out, DEFAULT_SEED);
    checkOutput("resetStep", {31'd0, prng_step}, 32'd0);
    checkOutput("resetReaddata", avs_readdata, 32'd0);
    readReg("resetCtrl", A_CTRL, 32'd0);
    readReg("resetSeed", A_SEED, 32'd0);
    readReg("resetDiv", A_DIV, 32'd0);
    readReg("resetCount", A_COUNT, 32'd0);

    // Seed 1 and two software steps.
    writeReg(A_SEED, 32'd1);
    writeReg(A_CTRL, 32'h4);
    modelState = 32'd1;
    checkOutput("reseedOne", prng_out, 32'd1);
    checkOutput("reseedOneStep", {31'd0, prng_step}, 32'd0);
    stepOnce("stepA");
    checkOutput("stepAKnown", prng_out, 32'h00042021);
    stepOnce("stepB");
    checkOutput("stepBKnown", prng_out, 32'h04080601);
    readReg("countTwo", A_COUNT, 32'd2);
    readReg("ctrlStepReadsZero", A_CTRL, 32'd0);

    // Zero seed falls back to the default and never locks up.
    writeReg(A_SEED, 32'd0);
    writeReg(A_CTRL, 32'h4);
    modelState = DEFAULT_SEED;
    checkOutput("zeroSeedOut", prng_out, DEFAULT_SEED);
    for (int i = 0; i < 6; i++) begin
      stepOnce("walk");
      checkOutput("walkNonZero", {31'd0, (prng_out != 32'd0)}, 32'd1);
    end
    readReg("countAfterWalk", A_COUNT, modelCount);

    // Free run with DIV=3: one pulse every 4 cycles, first 4 cycles after run.
    writeReg(A_DIV, 32'd3);
    writeReg(A_CTRL, 32'h1);
    checkOutput("div3Edge0", {31'd0, prng_step}, 32'd0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k % 4 == 0) begin
        modelState = refNext(modelState);
        modelCount = modelCount + 32'd1;
        checkOutput("div3Out", prng_out, modelState);
      end
      checkOutput("div3Pulse", {31'd0, prng_step}, {31'd0, (k % 4 == 0)});
    end
    writeReg(A_CTRL, 32'h0);
    for (int k = 0; k < 6; k++) begin
      checkOutput("stoppedPulse", {31'd0, prng_step}, 32'd0);
      @(negedge clk);
    end
    readReg("frozenCountA", A_COUNT, modelCount);
    repeat (5) @(negedge clk);
    readReg("frozenCountB", A_COUNT, modelCount);
    readReg("div3Read", A_DIV, 32'd3);
    checkOutput("stoppedOut", prng_out, modelState);

    // DIV=0 run, then run+reseed: no step in the reseed cycle, resumes next.
    writeReg(A_SEED, 32'hDEADBEEF);
    writeReg(A_DIV, 32'd0);
    writeReg(A_CTRL, 32'h1);
    checkOutput("div0Edge0", {31'd0, prng_step}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      modelState = refNext(modelState);
      modelCount = modelCount + 32'd1;
      checkOutput("div0Out", prng_out, modelState);
      checkOutput("div0Pulse", {31'd0, prng_step}, 32'd1);
    end
    writeReg(A_CTRL, 32'h5);
    modelState = 32'hDEADBEEF;
    checkOutput("runReseedOut", prng_out, 32'hDEADBEEF);
    checkOutput("runReseedNoPulse", {31'd0, prng_step}, 32'd0);
    @(negedge clk);
    modelState = refNext(modelState);
    modelCount = modelCount + 32'd1;
    checkOutput("resumeOut", prng_out, modelState);
    checkOutput("resumePulse", {31'd0, prng_step}, 32'd1);
    writeReg(A_CTRL, 32'h0);
    modelState = refNext(modelState);
    modelCount = modelCount + 32'd1;
    checkOutput("lastRunOut", prng_out, modelState);
    @(negedge clk);
    checkOutput("haltedPulse", {31'd0, prng_step}, 32'd0);
    readReg("runCount", A_COUNT, modelCount);
    readReg("seedRead", A_SEED, 32'hDEADBEEF);

    // COUNT write on the same edge as a step: clear wins.
    writeReg(A_CTRL, 32'h2);
    writeReg(A_COUNT, 32'd0);
    modelState = refNext(modelState);
    modelCount = 32'd0;
    checkOutput("clearStepOut", prng_out, modelState);
    checkOutput("clearStepPulse", {31'd0, prng_step}, 32'd1);
    readReg("clearWins", A_COUNT, modelCount);

    // Asynchronous reset in the middle of a DIV=0 run.
    writeReg(A_CTRL, 32'h1);
    repeat (2) @(negedge clk);
    modelState = refNext(refNext(modelState));
    checkOutput("preResetOut", prng_out, modelState);
    reset_n = 1'b0;
    #1;
    checkOutput("asyncResetOut", prng_out, DEFAULT_SEED);
    checkOutput("asyncResetStep", {31'd0, prng_step}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("postResetPulse", {31'd0, prng_step}, 32'd0);
      checkOutput("postResetOut", prng_out, DEFAULT_SEED);
    end
    readReg("postResetCtrl", A_CTRL, 32'd0);
    readReg("postResetCount", A_COUNT, 32'd0);
    readReg("postResetSeed", A_SEED, 32'd0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
